light_board_sequencer: RTL and testbench

- Parametrised successor to the fixed mode/board-select timer.
- Round-robins a one-hot enable across NUM_BOARDS light boards with a programmable dwell time per board, driving each board's configured mode.
- Supports priority override requests: the lowest index wins, as in the existing priority encoder.
- Sits between the control inputs and the light board instances.

---
 rtl/light_board_sequencer_if.sv | 25 ++
 rtl/light_board_sequencer.sv | 111 +++++++++++
 tb/tb_light_board_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/light_board_sequencer_if.sv
// light_board_sequencer_if: control inputs and board-drive outputs of the light board sequencer.
interface light_board_sequencer_if #(
    parameter int NUM_BOARDS = 4,
    parameter int SEL_W      = 2,
    parameter int MODE_W     = 2,
    parameter int DWELL_W    = 16
);
    logic                         enable;
    logic [DWELL_W-1:0]           dwell_cycles;
    logic [NUM_BOARDS-1:0]        req;
    logic [NUM_BOARDS*MODE_W-1:0] mode_cfg;
    logic [NUM_BOARDS-1:0]        board_en;
    logic [SEL_W-1:0]             board_sel;
    logic [MODE_W-1:0]            mode;
    logic                         override_active;
    logic                         wrap_pulse;
    modport master (
        output enable, dwell_cycles, req, mode_cfg,
        input  board_en, board_sel, mode, override_active, wrap_pulse
    );
    modport slave (
        input  enable, dwell_cycles, req, mode_cfg,
        output board_en, board_sel, mode, override_active, wrap_pulse
    );
endinterface

// File: rtl/light_board_sequencer.sv
// light_board_sequencer: round-robin one-hot board enable with per-board dwell and lowest-index override.
// Optional LB_MODE_ROTATE_EN adds a mode offset that advances on every scan wrap.
module light_board_sequencer #(
    parameter int NUM_BOARDS = 4,
    parameter int SEL_W      = 2,
    parameter int MODE_W     = 2,
    parameter int DWELL_W    = 16
) (
    input logic clk,
    input logic rst,
    light_board_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0, S_SCAN = 2'd1, S_OVR = 2'd2;
    logic [1:0]            r_state, w_state;
    logic [SEL_W-1:0]      r_sel, w_sel, r_saved_sel, w_saved_sel, w_req_idx;
    logic [DWELL_W-1:0]    r_cnt, w_cnt, r_dwell_last, w_dwell_last, w_dwell_new;
    logic [NUM_BOARDS-1:0] r_board_en;
    logic [MODE_W-1:0]     r_mode, w_mode, w_mode_base;
    logic                  r_ovr, r_wrap, w_wrap, w_req_any, w_last, w_expire;
    assign w_req_any   = |bus.req;
    assign w_last      = r_sel == SEL_W'(NUM_BOARDS - 1);
    assign w_expire    = r_cnt == r_dwell_last;
    assign w_dwell_new = (bus.dwell_cycles == '0) ? '0 : bus.dwell_cycles - 1'b1;
    // downward scan so the lowest set request is written last
    always_comb begin
        w_req_idx = '0;
        for (int i = NUM_BOARDS - 1; i >= 0; i--)
            if (bus.req[i]) w_req_idx = SEL_W'(i);
    end
    always_comb begin
        w_state      = r_state;
        w_sel        = r_sel;
        w_saved_sel  = r_saved_sel;
        w_cnt        = r_cnt;
        w_dwell_last = r_dwell_last;
        w_wrap       = 1'b0;
        if (!bus.enable) begin
            w_state     = S_IDLE;
            w_sel       = '0;
            w_saved_sel = '0;
            w_cnt       = '0;
        end else if (r_state == S_IDLE) begin
            w_state      = w_req_any ? S_OVR : S_SCAN;
            w_sel        = w_req_any ? w_req_idx : '0;
            w_saved_sel  = '0;
            w_cnt        = '0;
            w_dwell_last = w_dwell_new;
        end else if (r_state == S_SCAN) begin
            if (w_req_any) begin
                w_state     = S_OVR;
                w_sel       = w_req_idx;
                w_saved_sel = r_sel;
            end else if (w_expire) begin
                w_sel        = w_last ? '0 : r_sel + 1'b1;
                w_cnt        = '0;
                w_dwell_last = w_dwell_new;
                w_wrap       = w_last;
            end else begin
                w_cnt = r_cnt + 1'b1;
            end
        end else if (w_req_any) begin
            w_sel = w_req_idx;
        end else begin
            // interrupted board resumes with a fresh full dwell
            w_state      = S_SCAN;
            w_sel        = r_saved_sel;
            w_cnt        = '0;
            w_dwell_last = w_dwell_new;
        end
    end
    assign w_mode_base = bus.mode_cfg[w_sel*MODE_W +: MODE_W];
`ifdef LB_MODE_ROTATE_EN
    logic [MODE_W-1:0] r_mode_ofs, w_mode_ofs;
    assign w_mode_ofs = (w_state == S_IDLE) ? '0 : r_mode_ofs + MODE_W'(w_wrap);
    assign w_mode     = w_mode_base + w_mode_ofs;
    always_ff @(posedge clk) begin
        if (rst) r_mode_ofs <= '0;
        else     r_mode_ofs <= w_mode_ofs;
    end
`else
    assign w_mode = w_mode_base;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sel        <= '0;
            r_saved_sel  <= '0;
            r_cnt        <= '0;
            r_dwell_last <= '0;
            r_board_en   <= '0;
            r_mode       <= '0;
            r_ovr        <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_sel        <= w_sel;
            r_saved_sel  <= w_saved_sel;
            r_cnt        <= w_cnt;
            r_dwell_last <= w_dwell_last;
            r_board_en   <= (w_state == S_IDLE) ? '0 : NUM_BOARDS'(1) << w_sel;
            r_mode       <= (w_state == S_IDLE) ? '0 : w_mode;
            r_ovr        <= w_state == S_OVR;
            r_wrap       <= w_wrap;
        end
    end
    assign bus.board_en        = r_board_en;
    assign bus.board_sel       = r_sel;
    assign bus.mode            = r_mode;
    assign bus.override_active = r_ovr;
    assign bus.wrap_pulse      = r_wrap;
endmodule

// File: tb/tb_light_board_sequencer.sv
// tb_light_board_sequencer: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_light_board_sequencer;
    localparam int NB = 4, SW = 2, MW = 2, DW = 16;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    light_board_sequencer_if #(.NUM_BOARDS(NB), .SEL_W(SW), .MODE_W(MW), .DWELL_W(DW)) lb();
    light_board_sequencer #(.NUM_BOARDS(NB), .SEL_W(SW), .MODE_W(MW), .DWELL_W(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(lb)
    );
    int vectors = 0, miscompares = 0;
    int m_st = 0, m_sel = 0, m_cnt = 0, m_dl = 0, m_saved = 0, m_ofs = 0;
    logic [NB-1:0] e_en;
    logic [SW-1:0] e_sel;
    logic [MW-1:0] e_mode;
    logic          e_ovr, e_wrap;
`ifdef LB_MODE_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif
    // model states: 0 idle, 1 scanning, 2 override; advances one clock edge
    task automatic step();
        int  lo, dl_new;
        bit  wrap;
        lo = -1;
        for (int i = NB - 1; i >= 0; i--) if (lb.req[i]) lo = i;
        dl_new = (lb.dwell_cycles == 0) ? 0 : int'(lb.dwell_cycles) - 1;
        wrap = 1'b0;
        if (rst || !lb.enable) begin
            m_st = 0; m_sel = 0; m_cnt = 0; m_saved = 0; m_ofs = 0;
        end else if (m_st == 0) begin
            if (lo >= 0) begin m_st = 2; m_sel = lo; m_saved = 0; end
            else begin m_st = 1; m_sel = 0; m_cnt = 0; m_dl = dl_new; end
        end else if (m_st == 1) begin
            if (lo >= 0) begin m_st = 2; m_saved = m_sel; m_sel = lo; end
            else if (m_cnt == m_dl) begin
                m_sel = (m_sel + 1) % NB; m_cnt = 0; m_dl = dl_new; wrap = (m_sel == 0);
            end else m_cnt++;
        end else begin
            if (lo >= 0) m_sel = lo;
            else begin m_st = 1; m_sel = m_saved; m_cnt = 0; m_dl = dl_new; end
        end
        if (wrap && ROT) m_ofs = (m_ofs + 1) % (1 << MW);
        e_en   = (m_st == 0) ? '0 : NB'(1) << m_sel;
        e_sel  = (m_st == 0) ? '0 : SW'(m_sel);
        e_mode = (m_st == 0) ? '0 : MW'((lb.mode_cfg >> (m_sel * MW)) + m_ofs);
        e_ovr  = m_st == 2;
        e_wrap = wrap;
        @(posedge clk);
        #1;
    endtask
    task automatic restart(input int dwell);
        lb.enable = 1'b0; lb.req = '0;
        step();
        lb.dwell_cycles = DW'(dwell); lb.enable = 1'b1;
        step();
    endtask
    task automatic test_reset();
        rst = 1'b1; lb.enable = 1'b1; lb.req = '0; lb.dwell_cycles = 16'd3; lb.mode_cfg = 8'hA6;
        step(); step();
        vectors++;
        if ({lb.board_en, lb.board_sel, lb.mode, lb.override_active, lb.wrap_pulse} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset: en=%b sel=%0d mode=%0d ovr=%b wrap=%b, want all zero",
                     lb.board_en, lb.board_sel, lb.mode, lb.override_active, lb.wrap_pulse);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (lb.board_en !== 4'b0001 || lb.board_sel !== 2'd0 || lb.mode !== 2'd2 || lb.override_active !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: en=%b sel=%0d mode=%0d ovr=%b, want en=0001 sel=0 mode=2 ovr=0",
                     lb.board_en, lb.board_sel, lb.mode, lb.override_active);
        end
    endtask
    task automatic test_scan();
        restart(3);
        for (int k = 0; k < 13; k++) begin
            if (k > 0) step();
            vectors++;
            if (lb.board_sel !== SW'((k / 3) % NB) || lb.wrap_pulse !== (k == 12) || lb.board_en !== NB'(1) << ((k / 3) % NB)) begin
                miscompares++;
                $display("FAIL scan k=%0d: sel=%0d en=%b wrap=%b, want sel=%0d wrap=%b",
                         k, lb.board_sel, lb.board_en, lb.wrap_pulse, (k / 3) % NB, k == 12);
            end
        end
    endtask
    task automatic test_override();
        int exp_sel[6] = '{1, 2, 1, 1, 1, 2};
        bit exp_ovr[6] = '{1, 1, 0, 0, 0, 0};
        restart(3);
        repeat (4) step();
        lb.req = 4'b0110;
        for (int j = 0; j < 6; j++) begin
            step();
            if (j == 0) lb.req = 4'b0100;
            if (j == 1) lb.req = 4'b0000;
            vectors++;
            if (lb.board_sel !== SW'(exp_sel[j]) || lb.override_active !== exp_ovr[j]) begin
                miscompares++;
                $display("FAIL override j=%0d: sel=%0d ovr=%b, want sel=%0d ovr=%b",
                         j, lb.board_sel, lb.override_active, exp_sel[j], exp_ovr[j]);
            end
        end
    endtask
    task automatic test_dwell0_simul();
        restart(0);
        for (int k = 1; k < 3; k++) begin
            step();
            vectors++;
            if (lb.board_sel !== SW'(k)) begin
                miscompares++;
                $display("FAIL dwell0 k=%0d: sel=%0d, want %0d", k, lb.board_sel, k);
            end
        end
        lb.req = 4'b1000;
        step();
        vectors++;
        if (lb.board_sel !== 2'd3 || lb.override_active !== 1'b1 || lb.board_en !== 4'b1000 || lb.wrap_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL req_on_expiry: sel=%0d ovr=%b en=%b wrap=%b, want sel=3 ovr=1 en=1000 wrap=0",
                     lb.board_sel, lb.override_active, lb.board_en, lb.wrap_pulse);
        end
    endtask
    task automatic test_enable_reset();
        lb.enable = 1'b0;
        step();
        vectors++;
        if (lb.board_en !== 4'b0000 || lb.override_active !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_drop: en=%b ovr=%b, want en=0000 ovr=0", lb.board_en, lb.override_active);
        end
        lb.req = '0; lb.enable = 1'b1; lb.dwell_cycles = 16'd3;
        step();
        vectors++;
        if (lb.board_en !== 4'b0001 || lb.board_sel !== 2'd0) begin
            miscompares++;
            $display("FAIL reenable: en=%b sel=%0d, want en=0001 sel=0", lb.board_en, lb.board_sel);
        end
        step();
        rst = 1'b1;
        step();
        vectors++;
        if ({lb.board_en, lb.board_sel, lb.mode, lb.override_active, lb.wrap_pulse} !== 10'd0) begin
            miscompares++;
            $display("FAIL rst_mid_dwell: en=%b sel=%0d mode=%0d ovr=%b, want all zero",
                     lb.board_en, lb.board_sel, lb.mode, lb.override_active);
        end
        rst = 1'b0;
    endtask
    task automatic test_mode_rotate();
        lb.mode_cfg = '0;
        restart(1);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) step();
            vectors++;
            if (lb.mode !== (ROT ? MW'(k / 4) : MW'(0))) begin
                miscompares++;
                $display("FAIL mode_rotate k=%0d: mode=%0d, want %0d", k, lb.mode, ROT ? (k / 4) % 4 : 0);
            end
        end
    endtask
    task automatic test_random();
        lb.mode_cfg = 8'h1B;
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            lb.enable = ($urandom_range(0, 29) != 0);
            lb.req = ($urandom_range(0, 5) == 0) ? NB'($urandom) : '0;
            lb.dwell_cycles = DW'($urandom_range(0, 4));
            if ($urandom_range(0, 9) == 0) lb.mode_cfg = 8'($urandom);
            step();
            vectors++;
            if ({lb.board_en, lb.board_sel, lb.mode, lb.override_active, lb.wrap_pulse} !== {e_en, e_sel, e_mode, e_ovr, e_wrap}) begin
                miscompares++;
                $display("FAIL random c=%0d: en=%b sel=%0d mode=%0d ovr=%b wrap=%b, want en=%b sel=%0d mode=%0d ovr=%b wrap=%b",
                         c, lb.board_en, lb.board_sel, lb.mode, lb.override_active, lb.wrap_pulse,
                         e_en, e_sel, e_mode, e_ovr, e_wrap);
            end
        end
        rst = 1'b0;
    endtask
    initial begin
        test_reset();
        test_scan();
        test_override();
        test_dwell0_simul();
        test_enable_reset();
        test_mode_rotate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
